// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, default timings and command bytes
package ps2_pkg;

  // Transmitter state encoding
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RTS      = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    STOP     = 3'd4,
    ACK      = 3'd5,
    WAIT_REL = 3'd6
  } ps2_state_t;

  // Default timings at 50 MHz: 100 us request-to-send, 15 ms watchdog
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_FILTER_LEN     = 8;

  // Common keyboard command bytes
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Nine-bit payload as shifted out LSB first: {odd parity, data}
  function automatic logic [8:0] ps2_frame(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - ps2c glitch filter producing a clean level and a falling-edge pulse
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall_edge
);

  logic [FILTER_LEN-1:0] r_shift;
  logic                  r_level;
  logic                  r_fall;
  logic [FILTER_LEN-1:0] w_shift_next;
  logic                  w_level_next;

  assign w_shift_next = {r_shift[FILTER_LEN-2:0], i_line};

  // Level changes only once the whole window agrees; mixed windows hold the old level
  always_comb begin
    w_level_next = r_level;
    if (&w_shift_next) begin
      w_level_next = 1'b1;
    end else if (~|w_shift_next) begin
      w_level_next = 1'b0;
    end
  end

  // Sample history, filtered level and one-cycle fall pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_level <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_level <= w_level_next;
      r_fall  <= r_level & ~w_level_next;
    end
  end

  assign o_level     = r_level;
  assign o_fall_edge = r_fall;

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter; optional watchdog under PS2_TX_TIMEOUT_EN
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
`ifdef PS2_TX_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  ps2_state_t            r_state;
  logic [CNT_W-1:0]      r_count;
  logic [8:0]            r_frame;
  logic [3:0]            r_n;
  logic                  r_ps2c_oe;
  logic                  r_ps2d_oe;
  logic                  r_tx_idle;
  logic                  r_done;
  logic                  r_ack_smp;
  logic                  r_ack_err;
  logic [FILTER_LEN-1:0] r_d_shift;
  logic                  r_d_level;
  logic [FILTER_LEN-1:0] w_d_shift_next;
  logic                  w_c_level;
  logic                  w_c_fall;

  // Clock line conditioning shared with the receiver
  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk         (clk),
    .rst         (rst),
    .i_line      (ps2c_in),
    .o_level     (w_c_level),
    .o_fall_edge (w_c_fall)
  );

  assign w_d_shift_next = {r_d_shift[FILTER_LEN-2:0], ps2d_in};

  // Data line level filter, used to read the device acknowledge bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_shift <= '0;
      r_d_level <= 1'b0;
    end else begin
      r_d_shift <= w_d_shift_next;
      if (&w_d_shift_next) begin
        r_d_level <= 1'b1;
      end else if (~|w_d_shift_next) begin
        r_d_level <= 1'b0;
      end
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wdog_expired;

  assign w_wdog_expired = (r_state != IDLE) && (r_state != RTS) &&
                          (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog runs from the end of request-to-send until the FSM is back in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == IDLE || r_state == RTS || w_wdog_expired) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`endif

  // Transfer sequencer; all line drives and status are registered here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_frame   <= '0;
      r_n       <= '0;
      r_ps2c_oe <= 1'b0;
      r_ps2d_oe <= 1'b0;
      r_tx_idle <= 1'b1;
      r_done    <= 1'b0;
      r_ack_smp <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      if (w_wdog_expired) begin
        // Device stopped clocking: give the bus back and report a failed transfer
        r_ps2c_oe <= 1'b0;
        r_ps2d_oe <= 1'b0;
        r_ack_err <= 1'b1;
        r_done    <= 1'b1;
        r_tx_idle <= 1'b1;
        r_state   <= IDLE;
      end else begin
`endif
      case (r_state)
        IDLE: begin
          r_ps2c_oe <= 1'b0;
          r_ps2d_oe <= 1'b0;
          r_tx_idle <= 1'b1;
          if (wr_ps2) begin
            r_frame   <= ps2_frame(din);
            r_count   <= CNT_W'(INHIBIT_CYCLES - 1);
            r_ps2c_oe <= 1'b1;
            r_tx_idle <= 1'b0;
            r_state   <= RTS;
          end
        end
        RTS: begin
          // Hold the clock low, then swap to data low as the start bit
          if (r_count == '0) begin
            r_ps2c_oe <= 1'b0;
            r_ps2d_oe <= 1'b1;
            r_state   <= START;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        START: begin
          if (w_c_fall) begin
            r_ps2d_oe <= ~r_frame[0];
            r_n       <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          // Eight data bits then parity; the ninth fall ends the parity bit
          if (w_c_fall) begin
            if (r_n == 4'd8) begin
              r_ps2d_oe <= 1'b0;
              r_state   <= STOP;
            end else begin
              r_frame   <= {1'b0, r_frame[8:1]};
              r_ps2d_oe <= ~r_frame[1];
              r_n       <= r_n + 1'b1;
            end
          end
        end
        STOP: begin
          r_ps2d_oe <= 1'b0;
          if (w_c_fall) begin
            r_state <= ACK;
          end
        end
        ACK: begin
          // Device pulls data low to acknowledge; a high line means no ACK
          if (w_c_fall) begin
            r_ack_smp <= r_d_level;
            r_state   <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (ps2d_in && w_c_level) begin
            r_ack_err <= r_ack_smp;
            r_done    <= 1'b1;
            r_tx_idle <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_ps2c_oe <= 1'b0;
          r_ps2d_oe <= 1'b0;
          r_tx_idle <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      end
`endif
    end
  end

  assign ps2c_oe      = r_ps2c_oe;
  assign ps2d_oe      = r_ps2d_oe;
  assign tx_idle      = r_tx_idle;
  assign tx_done_tick = r_done;
  assign ack_err      = r_ack_err;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - directed self-checking bench for ps2_tx with a wired-AND device model
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH        = 5000;
  localparam int HALF       = 30;
  localparam int TB_TIMEOUT = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       dev_c;
  logic       dev_d;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  int         vectors     = 0;
  int         miscompares = 0;
  int         done_cnt    = 0;
  int         c_hi;
  int         base;
  bit         ok;
  logic [10:0] rec;
  logic       ack_at_r12;

  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  always #5 clk = ~clk;

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
`ifdef PS2_TX_TIMEOUT_EN
    .TIMEOUT_CYCLES (TB_TIMEOUT),
`endif
    .FILTER_LEN     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .ack_err      (ack_err)
  );

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'h00;
  endtask

  // Count ps2c_oe cycles until the host swaps to the start bit
  task automatic dev_rts();
    c_hi = (ps2c_oe === 1'b1) ? 1 : 0;
    ok   = 1'b0;
    for (int k = 0; k < INH + 200; k++) begin
      @(negedge clk);
      if (ps2d_oe === 1'b1 && ps2c_oe === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (ps2c_oe === 1'b1) c_hi++;
    end
  endtask

  task automatic dev_start();
    repeat (50) @(negedge clk);
    rec[0] = ps2d_in;
  endtask

  // Device clock pulses first..last; data sampled on each rising edge
  task automatic dev_clocks(input int first, input int last, input bit do_ack, input int glitch);
    for (int i = first; i <= last; i++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_c = 1'b1;
      if (i == 12) begin
        dev_d      = 1'b1;
        ack_at_r12 = ack_err;
      end
      if (i <= 10) rec[i] = ps2d_in;
      if (glitch == i) begin
        repeat (10) @(negedge clk);
        dev_c = 1'b0;
        repeat (3) @(negedge clk);
        dev_c = 1'b1;
        repeat (HALF - 13) @(negedge clk);
      end else if (i == 11 && do_ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_d = 1'b0;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle();
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (tx_idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input bit do_ack, input int glitch,
                      input int restrobe, input logic [10:0] exp_bits, input logic exp_ack,
                      input logic prev_ack);
    base = done_cnt;
    send(b);
    check({tag, "_idle_low"}, tx_idle, 1'b0);
    check({tag, "_rts_oe"}, ps2c_oe, 1'b1);
    dev_rts();
    check({tag, "_rts_seen"}, ok, 1'b1);
    check({tag, "_inhibit_cycles"}, c_hi, INH);
    dev_start();
    if (restrobe > 0) begin
      dev_clocks(1, restrobe, do_ack, glitch);
      send(CMD_RESET);
      dev_clocks(restrobe + 1, 12, do_ack, glitch);
    end else begin
      dev_clocks(1, 12, do_ack, glitch);
    end
    wait_idle();
    check({tag, "_idle_return"}, ok, 1'b1);
    repeat (2) @(negedge clk);
    check({tag, "_bits"}, rec, exp_bits);
    check({tag, "_done_pulses"}, done_cnt - base, 1);
    check({tag, "_ack_hold"}, ack_at_r12, prev_ack);
    check({tag, "_ack_err"}, ack_err, exp_ack);
    check({tag, "_lines_released"}, {ps2c_oe, ps2d_oe}, 2'b00);
  endtask

  initial begin
    rst        = 1'b0;
    dev_c      = 1'b1;
    dev_d      = 1'b1;
    wr_ps2     = 1'b0;
    din        = 8'h00;
    ack_at_r12 = 1'b0;
    rec        = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ps2c_oe", ps2c_oe, 1'b0);
    check("reset_ps2d_oe", ps2d_oe, 1'b0);
    check("reset_tx_idle", tx_idle, 1'b1);
    check("reset_done", tx_done_tick, 1'b0);
    check("reset_ack_err", ack_err, 1'b0);
    repeat (20) @(negedge clk);

    // 0xED: parity 1, device acknowledges
    xfer("ed", CMD_SET_LEDS, 1'b1, 0, 0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0, 1'b0);
    // 0x00: parity 1, device omits ACK
    xfer("noack", 8'h00, 1'b0, 0, 0, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b0);
    // 0x07: parity 0, 0xFF strobed after bit 2 must be ignored
    xfer("restrobe", 8'h07, 1'b1, 0, 3, {1'b1, 1'b0, 8'h07, 1'b0}, 1'b0, 1'b1);
    // 0xA5: parity 1, 3-cycle low glitch during pulse 5 high phase
    xfer("glitch", 8'hA5, 1'b1, 5, 0, {1'b1, 1'b1, 8'hA5, 1'b0}, 1'b0, 1'b0);

    // Asynchronous reset while bit 4 is on the line
    send(8'h00);
    dev_rts();
    check("rst_rts_seen", ok, 1'b1);
    dev_start();
    dev_clocks(1, 4, 1'b1, 0);
    dev_c = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_pre_ps2d_oe", ps2d_oe, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_ps2c_oe", ps2c_oe, 1'b0);
    check("rst_async_ps2d_oe", ps2d_oe, 1'b0);
    check("rst_async_tx_idle", tx_idle, 1'b1);
    @(negedge clk);
    rst   = 1'b1;
    dev_c = 1'b1;
    repeat (20) @(negedge clk);

    // 0xF4: parity 0, normal transfer after the reset
    xfer("f4", CMD_ENABLE, 1'b1, 0, 0, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0, 1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    // Device never clocks: watchdog ends the transfer TB_TIMEOUT cycles after RTS
    base = done_cnt;
    send(CMD_RESET);
    dev_rts();
    check("to_rts_seen", ok, 1'b1);
    c_hi = 0;
    for (int k = 0; k < 2 * TB_TIMEOUT; k++) begin
      @(negedge clk);
      c_hi++;
      if (tx_done_tick === 1'b1) break;
    end
    check("to_cycles", c_hi, TB_TIMEOUT);
    check("to_lines_released", {ps2c_oe, ps2d_oe}, 2'b00);
    check("to_tx_idle", tx_idle, 1'b1);
    check("to_ack_err", ack_err, 1'b1);
    repeat (5) @(negedge clk);
    check("to_done_pulses", done_cnt - base, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
